// File: rtl/seed_load_ctrl.sv
// Seed/key load sequencer: arbitrates two 32-bit word sources into the seed FIFO,
// then launches AES-256 key expansion. Define SEED_LOAD_CTRL_RR_EN for round-robin ties.
module seed_load_ctrl #(
  parameter int WORDS   = 8,
  parameter int DATA_WH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req,
  input  logic [1:0]         i_valid,
  input  logic [DATA_WH-1:0] i_data0,
  input  logic [DATA_WH-1:0] i_data1,
  output logic [1:0]         o_ready,
  output logic [1:0]         o_grant,
  output logic               o_fifo_write,
  output logic [DATA_WH-1:0] o_fifo_data,
  output logic               o_fifo_resetn,
  input  logic               i_fifo_read,
  output logic               o_key_start,
  input  logic               i_key_done,
  output logic               o_busy,
  output logic               o_seed_loaded,
  output logic               o_abort
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_RD, S_EXPAND} state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_grant, w_arb;
  logic [WW-1:0]      r_wcnt;
  logic [TW-1:0]      r_tcnt;
  logic               r_fifo_write, r_fifo_resetn, r_key_start, r_busy, r_seed_loaded, r_abort;
  logic [DATA_WH-1:0] r_fifo_data;
  logic               w_accept, w_tmo, w_last;

  assign o_ready  = (r_state == S_LOAD) ? r_grant : 2'b00;
  assign w_accept = |(i_valid & o_ready);
  // Abort is decided in the cycle the idle counter holds TIMEOUT and beats any word offered then.
  assign w_tmo    = (r_state == S_LOAD) && (r_tcnt == TW'(TIMEOUT));
  assign w_last   = w_accept && (r_wcnt == WW'(WORDS - 1));

`ifdef SEED_LOAD_CTRL_RR_EN
  logic r_ptr;  // preferred requester on a tie

  always_comb begin
    w_arb = 2'b00;
    case (i_req)
      2'b01:   w_arb = 2'b01;
      2'b10:   w_arb = 2'b10;
      2'b11:   w_arb = r_ptr ? 2'b10 : 2'b01;
      default: w_arb = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_ptr <= 1'b0;
    else if (r_state == S_EXPAND && i_key_done)
      r_ptr <= r_grant[0];
  end
`else
  always_comb begin
    w_arb = 2'b00;
    if (i_req[0])      w_arb = 2'b01;
    else if (i_req[1]) w_arb = 2'b10;
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|i_req) w_next = S_LOAD;
      S_LOAD:    if (w_tmo) w_next = S_IDLE;
                 else if (w_last) w_next = S_WAIT_RD;
      S_WAIT_RD: if (i_fifo_read) w_next = S_EXPAND;
      S_EXPAND:  if (i_key_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'b00;
      r_wcnt        <= '0;
      r_tcnt        <= '0;
      r_fifo_write  <= 1'b0;
      r_fifo_data   <= '0;
      r_fifo_resetn <= 1'b0;
      r_key_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_seed_loaded <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_busy        <= (w_next != S_IDLE);
      r_fifo_write  <= w_accept && !w_tmo;
      r_fifo_resetn <= !w_tmo;
      r_abort       <= w_tmo;
      r_key_start   <= (r_state == S_WAIT_RD) && i_fifo_read;
      r_seed_loaded <= (r_state == S_EXPAND) && i_key_done;
      if (w_accept && !w_tmo)
        r_fifo_data <= r_grant[1] ? i_data1 : i_data0;
      case (r_state)
        S_IDLE: if (|i_req) begin
          r_grant <= w_arb;
          r_wcnt  <= '0;
          r_tcnt  <= '0;
        end
        S_LOAD: begin
          if (w_tmo) begin
            r_grant <= 2'b00;
          end else if (w_accept) begin
            r_wcnt <= r_wcnt + WW'(1);
            r_tcnt <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_EXPAND: if (i_key_done) r_grant <= 2'b00;
        default: ;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_fifo_write  = r_fifo_write;
  assign o_fifo_data   = r_fifo_data;
  assign o_fifo_resetn = r_fifo_resetn;
  assign o_key_start   = r_key_start;
  assign o_busy        = r_busy;
  assign o_seed_loaded = r_seed_loaded;
  assign o_abort       = r_abort;

endmodule

// File: doc/seed_load_ctrl.md
Name: seed_load_ctrl

Overview:
Controller that sequences 256-bit seed/key loading into the seed FIFO (32-bit in, 256-bit out) and hands the assembled key to the AES-256 key-expansion engine. Arbitrates the FIFO between two 32-bit word sources: requester 0 (host register interface) and requester 1 (TRNG/seed generator). Owns the FIFO write strobe and the FIFO's active-low reset. Launches key expansion and waits for completion.

Parameters:
WORDS, 8, 32-bit words per seed; must equal the FIFO depth.
DATA_WH, 32, word width.
TIMEOUT, 255, maximum consecutive idle cycles in LOAD before abort; counter width is clog2(TIMEOUT+1).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
req  in  2  per-requester load request; bit i belongs to requester i.
valid  in  2  per-requester word valid.
data0  in  DATA_WH  requester 0 word.
data1  in  DATA_WH  requester 1 word.
ready  out  2  per-requester word ready; one-hot or zero.
grant  out  2  one-hot owner of the current load; zero when idle.
fifo_write  out  1  FIFO write strobe.
fifo_data  out  DATA_WH  FIFO write data.
fifo_resetn  out  1  active-low reset to the FIFO.
fifo_read  in  1  FIFO 256-bit output valid pulse.
key_start  out  1  one-cycle key-expansion start.
key_done  in  1  key expansion complete (pulse or level).
busy  out  1  high in every state except IDLE.
seed_loaded  out  1  one-cycle pulse on successful completion.
abort  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. grant, ready, fifo_write, key_start, busy, seed_loaded and abort go to 0. fifo_data goes to 0. fifo_resetn goes to 0. Word and timeout counters clear. Round-robin pointer selects requester 0.
- fifo_resetn returns to 1 on the first cycle after rst deasserts. Reset mid-operation drops any partial load without further pulses.
- IDLE:
  - If req != 0, arbitrate, register the one-hot grant, clear word_cnt and the timeout counter, and go to LOAD.
  - Arbitration is round-robin: the requester not served last wins a tie.
  - A single requester always wins.
- LOAD:
  - ready[i] = grant[i] and state==LOAD, combinational from registered state.
  - A word is accepted when valid[g] and ready[g] are both high.
  - On acceptance, fifo_write=1 and fifo_data = the granted data on the next cycle (1-cycle registered latency). fifo_write is 0 otherwise.
  - word_cnt increments on each acceptance. The WORDS-th acceptance moves to WAIT_RD; ready drops in that same cycle, so no extra word is taken.
  - The timeout counter clears on each acceptance and increments on each idle cycle.
  - When the counter reaches TIMEOUT: pulse abort, pulse fifo_resetn low for 1 cycle (this discards the partial words and the FIFO pointer), release grant, go to IDLE.
  - Deassertion of req during LOAD is ignored; only the timeout ends a stalled load.
- WAIT_RD:
  - Wait for fifo_read, which the FIFO raises on the cycle it becomes full.
  - On fifo_read, assert key_start for exactly 1 cycle (next cycle) and go to EXPAND.
  - A fifo_read seen in any other state is ignored.
- EXPAND:
  - Wait for key_done, with no timeout.
  - On key_done: pulse seed_loaded, point the round-robin pointer away from the served requester, clear grant, go to IDLE.
  - key_done seen outside EXPAND is ignored.
- Back-to-back loads: a requester holding req re-arbitrates in the IDLE cycle after completion. There is a minimum 1 IDLE cycle between loads.
- busy = (state != IDLE), registered.
- Priority of simultaneous events: rst > timeout abort > word acceptance.

Optional Feature:
Macro SEED_LOAD_CTRL_RR_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, requester 0 always wins ties. The round-robin pointer logic is not built, and requester 1 can starve.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> grant=0, busy=0, fifo_resetn=0 during reset and 1 afterwards, fifo_write never asserted.
- Single full load: req=01, 8 back-to-back words 0x11111111..0x88888888, FIFO model asserts fifo_read after the 8th write -> 8 fifo_write pulses with matching data, each 1 cycle after acceptance. key_start pulses once; after key_done, seed_loaded pulses once and state returns to IDLE.
- Stalled load: requester drops valid after 3 words for TIMEOUT cycles -> abort and a 1-cycle fifo_resetn low pulse exactly at cycle TIMEOUT, grant=0, no key_start.
- Arbitration, with RR_EN defined: req=11 held through two loads -> first grant=01, second grant=10. Undefined: both grants=01.
- Reset mid-EXPAND: rst asserted while waiting for key_done -> all outputs at reset values on the next cycle. A later key_done produces no seed_loaded.
- Gapped valid: valid toggles every other cycle -> 8 words accepted, no timeout, fifo_data order preserved.
